// File: rtl/nx_ram_pkg.sv
// Shared types and defaults for the nx_ram port arbiter and its clients.
package nx_ram_pkg;

  localparam int unsigned NX_RAM_ADDRESS_WIDTH = 10;
  localparam int unsigned NX_RAM_DATA_WIDTH    = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } nx_ram_arb_state_t;

  // Round-robin successor of a granted index, wrapping at n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N-1.
// Zero latency; callers apply their own stall by masking the result.
module nx_rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/nx_ram_arbiter.sv
// Round-robin share of one nx_ram port; read data returns one cycle after accept.
// A stalled response is parked in hold_q and blocks new grants until it is taken.
module nx_ram_arbiter
  import nx_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = NX_RAM_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = NX_RAM_DATA_WIDTH,
  parameter int REQUESTERS    = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [REQUESTERS-1:0]                    req_valid_i,
  output logic [REQUESTERS-1:0]                    req_ready_o,
  input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [REQUESTERS-1:0]                    req_wr_en_i,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]    req_wr_data_i,
  output logic [REQUESTERS-1:0]                    rsp_valid_o,
  input  logic [REQUESTERS-1:0]                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                    rsp_data_o,
  output logic                                     ram_en_o,
  output logic                                     ram_wr_en_o,
  output logic [ADDRESS_WIDTH-1:0]                 ram_addr_o,
  output logic [DATA_WIDTH-1:0]                    ram_wr_data_o,
  input  logic [DATA_WIDTH-1:0]                    ram_rd_data_i
);

  localparam int RQ_W = $clog2(REQUESTERS);

  nx_ram_arb_state_t     state_q;
  logic [RQ_W-1:0]       own_q;
  logic [RQ_W-1:0]       rr_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic [REQUESTERS-1:0] pick_oh;
  logic [RQ_W-1:0]       pick_idx;
  logic                  pick_any;
  logic                  own_rdy;
  logic                  grant_ok;
  logic                  grant;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  rsp_active;

  nx_rr_arbiter #(
    .N (REQUESTERS),
    .W (RQ_W)
  ) u_rr (
    .req (req_valid_i),
    .ptr (rr_q),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // In RESP the owner's ready feeds straight into the next grant decision.
  assign own_rdy  = rsp_ready_i[own_q];
  assign grant_ok = rst_i && ((state_q == IDLE) || (state_q == RESP && own_rdy));
  assign grant    = grant_ok && pick_any;
  assign grant_wr = grant && req_wr_en_i[pick_idx];
  assign grant_rd = grant && !req_wr_en_i[pick_idx];

  assign req_ready_o   = grant ? pick_oh : '0;
  assign ram_en_o      = grant;
  assign ram_wr_en_o   = grant_wr;
  assign ram_addr_o    = grant ? req_addr_i[pick_idx] : '0;
  assign ram_wr_data_o = grant ? req_wr_data_i[pick_idx] : '0;

  assign rsp_active = rst_i && (state_q != IDLE);

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (rsp_active) begin
      rsp_valid_o[own_q] = 1'b1;
      rsp_data_o         = (state_q == HOLD) ? hold_q : ram_rd_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q <= '0;
    end else if (grant) begin
      rr_q <= RQ_W'(rr_next(32'(pick_idx), REQUESTERS));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      own_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_rd) begin
            own_q   <= pick_idx;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (own_rdy) begin
            if (grant_rd) begin
              own_q   <= pick_idx;
              state_q <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            // RAM output is only valid for one cycle; park it before it changes.
            hold_q  <= ram_rd_data_i;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (own_rdy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nx_ram_arbiter.sv
// Directed bench for nx_ram_arbiter with a behavioural RAM and a response scoreboard.
module tb_nx_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 36;
  localparam int RQ = 2;

  localparam logic [DW-1:0] D1 = 36'h111111111;
  localparam logic [DW-1:0] D2 = 36'h222222222;
  localparam logic [DW-1:0] D3 = 36'hFEDCBA987;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [RQ-1:0]          req_valid_i;
  logic [RQ-1:0]          req_ready_o;
  logic [RQ-1:0][AW-1:0]  req_addr_i;
  logic [RQ-1:0]          req_wr_en_i;
  logic [RQ-1:0][DW-1:0]  req_wr_data_i;
  logic [RQ-1:0]          rsp_valid_o;
  logic [RQ-1:0]          rsp_ready_i;
  logic [DW-1:0]          rsp_data_o;
  logic                   ram_en_o;
  logic                   ram_wr_en_o;
  logic [AW-1:0]          ram_addr_o;
  logic [DW-1:0]          ram_wr_data_o;
  logic [DW-1:0]          ram_rd_data_i;

  always #5 clk_i = ~clk_i;

  nx_ram_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .REQUESTERS    (RQ)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_wr_en_i   (req_wr_en_i),
    .req_wr_data_i (req_wr_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .ram_en_o      (ram_en_o),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .ram_rd_data_i (ram_rd_data_i)
  );

  // RAM: one-cycle read latency; output is junk on cycles without a read.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk_i) begin
    ram_rd_data_i <= (ram_en_o && !ram_wr_en_o) ? mem[ram_addr_o] : 36'hDEADBEEF0;
    if (ram_en_o && ram_wr_en_o) mem[ram_addr_o] = ram_wr_data_o;
  end

  typedef struct packed {
    logic [0:0]    cl;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic push(input int c, input logic [DW-1:0] d);
    sb.push_back(exp_t'{cl: c[0], d: d});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i   = '0;
    req_wr_en_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
  endtask

  // Response monitor: pops on every response handshake.
  always @(negedge clk_i) begin
    if (rsp_valid_o != '0) begin
      chk("rsp_onehot", 64'($onehot(rsp_valid_o)), 64'd1);
      for (int i = 0; i < RQ; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: client %0d data %0h, nothing expected", i, rsp_data_o);
          end else begin
            e = sb.pop_front();
            chk("rsp_client", 64'(i), 64'(e.cl));
            chk("rsp_data", 64'(rsp_data_o), 64'(e.d));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[1]      = D1;
    mem[2]      = D2;
    mem[10'h3FF] = D3;

    // Reset: requests present but everything must stay quiet.
    rst_i = 1'b0;
    idle_inputs();
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_ram_en", 64'(ram_en_o), 64'd0);
    chk("rst_ram_wr_en", 64'(ram_wr_en_o), 64'd0);
    step();
    idle_inputs();
    rst_i = 1'b1;

    // Write then read.
    req_valid_i      = 2'b01;
    req_wr_en_i      = 2'b01;
    req_addr_i[0]    = 10'h005;
    req_wr_data_i[0] = 36'h123456789;
    @(negedge clk_i);
    chk("t1_wr_ready", 64'(req_ready_o), 64'h1);
    chk("t1_wr_ram_en", 64'(ram_en_o), 64'h1);
    chk("t1_wr_ram_wr_en", 64'(ram_wr_en_o), 64'h1);
    chk("t1_wr_addr", 64'(ram_addr_o), 64'h005);
    chk("t1_wr_data", 64'(ram_wr_data_o), 64'h123456789);
    step();
    req_wr_en_i = 2'b00;
    @(negedge clk_i);
    chk("t1_rd_ready", 64'(req_ready_o), 64'h1);
    chk("t1_rd_ram_wr_en", 64'(ram_wr_en_o), 64'h0);
    push(0, 36'h123456789);
    step();
    idle_inputs();
    @(negedge clk_i);
    chk("t1_rsp_valid", 64'(rsp_valid_o), 64'h1);
    step();

    // Contention from reset: grants alternate 0,1,0,1.
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    req_valid_i   = 2'b11;
    req_addr_i[0] = 10'h001;
    req_addr_i[1] = 10'h002;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("t2_grant", 64'(req_ready_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) chk("t2_rsp_valid", 64'(rsp_valid_o), (k % 2 == 1) ? 64'h1 : 64'h2);
      push(k % 2, (k % 2 == 0) ? D1 : D2);
      step();
    end
    idle_inputs();
    @(negedge clk_i);
    chk("t2_last_rsp", 64'(rsp_valid_o), 64'h2);
    step();
    @(negedge clk_i);
    chk("t2_idle", 64'(rsp_valid_o), 64'h0);
    step();

    // Backpressure: client 1 stalls its response for three cycles.
    req_valid_i   = 2'b10;
    req_addr_i[1] = 10'h3FF;
    rsp_ready_i   = 2'b01;
    @(negedge clk_i);
    chk("t3_c1_grant", 64'(req_ready_o), 64'h2);
    push(1, D3);
    step();
    req_valid_i   = 2'b01;
    req_addr_i[0] = 10'h001;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_i);
      chk("t3_stall_ready", 64'(req_ready_o), 64'h0);
      chk("t3_stall_valid", 64'(rsp_valid_o), 64'h2);
      chk("t3_stall_data", 64'(rsp_data_o), 64'(D3));
      step();
    end
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("t3_release_noready", 64'(req_ready_o), 64'h0);
    chk("t3_release_valid", 64'(rsp_valid_o), 64'h2);
    step();
    @(negedge clk_i);
    chk("t3_c0_grant", 64'(req_ready_o), 64'h1);
    chk("t3_c0_no_rsp", 64'(rsp_valid_o), 64'h0);
    push(0, D1);
    step();
    idle_inputs();
    @(negedge clk_i);
    chk("t3_c0_rsp", 64'(rsp_valid_o), 64'h1);
    step();

    // Write-only stream of 16 words.
    req_valid_i = 2'b01;
    req_wr_en_i = 2'b01;
    for (int i = 0; i < 16; i++) begin
      req_addr_i[0]    = AW'(i);
      req_wr_data_i[0] = 36'hA50000000 + DW'(i);
      @(negedge clk_i);
      chk("t4_ready", 64'(req_ready_o), 64'h1);
      chk("t4_wr_en", 64'(ram_wr_en_o), 64'h1);
      chk("t4_addr", 64'(ram_addr_o), 64'(i));
      chk("t4_no_rsp", 64'(rsp_valid_o), 64'h0);
      step();
    end
    req_wr_en_i   = 2'b00;
    req_addr_i[0] = 10'h00A;
    @(negedge clk_i);
    chk("t4_rdback_ready", 64'(req_ready_o), 64'h1);
    push(0, 36'hA5000000A);
    step();
    idle_inputs();
    @(negedge clk_i);
    chk("t4_rdback_rsp", 64'(rsp_valid_o), 64'h1);
    step();

    // Reset during the response cycle of a read.
    req_valid_i   = 2'b01;
    req_addr_i[0] = 10'h003;
    @(negedge clk_i);
    chk("t5_rd_ready", 64'(req_ready_o), 64'h1);
    step();
    req_valid_i   = 2'b11;
    req_addr_i[1] = 10'h002;
    #1;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_req_ready", 64'(req_ready_o), 64'h0);
    chk("t5_rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("t5_rst_ram_en", 64'(ram_en_o), 64'h0);
    chk("t5_rst_ram_wr_en", 64'(ram_wr_en_o), 64'h0);
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_first_grant", 64'(req_ready_o), 64'h1);
    chk("t5_no_stale_rsp", 64'(rsp_valid_o), 64'h0);
    push(0, 36'hA50000003);
    step();
    @(negedge clk_i);
    chk("t5_second_grant", 64'(req_ready_o), 64'h2);
    chk("t5_rsp0", 64'(rsp_valid_o), 64'h1);
    push(1, 36'hA50000002);
    step();
    idle_inputs();
    @(negedge clk_i);
    chk("t5_rsp1", 64'(rsp_valid_o), 64'h2);
    step();
    @(negedge clk_i);
    chk("t5_idle", 64'(rsp_valid_o), 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
